// File: rtl/ram_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// ram_bus_pkg : shared types and helpers for the PicoRV32-to-user-RAM bridge
// Revision    : 1.0
// ============================================================================
package ram_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD0      = 3'd1,
    ST_RD1      = 3'd2,
    ST_MERGE_WR = 3'd3,
    ST_WR       = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  // The RAM drives this on ram_do while it has no valid read data.
  localparam logic [31:0] RAM_IDLE_PATTERN = 32'h1611_0400;

  function automatic logic [31:0] merge_bytes(input logic [3:0]  wstrb,
                                              input logic [31:0] new_data,
                                              input logic [31:0] old_data);
    logic [31:0] res;
    res = old_data;
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) res[8*k +: 8] = new_data[8*k +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_bridge.sv
`default_nettype none
// ============================================================================
// ram_bus_bridge : PicoRV32 native bus to single-port user RAM strobe initiator
// Revision       : 1.0
// ============================================================================
module ram_bus_bridge
  import ram_bus_pkg::*;
#(
  parameter int          ADDR_BIT  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i
);

  localparam int TAG_LSB = ADDR_BIT + 2;

  state_e              state_q, state_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                rmw_q, rmw_d;
  logic [31:0]         di_q, di_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                ready_q, ready_d;
  logic                sel;
  logic                unused_byte_offset;

  assign sel = mem_valid_i && (mem_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign unused_byte_offset = ^mem_addr_i[1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rmw_d   = rmw_q;
    di_d    = di_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel) begin
          addr_d  = mem_addr_i[ADDR_BIT+1:2];
          wdata_d = mem_wdata_i;
          wstrb_d = mem_wstrb_i;
          if (mem_wstrb_i == 4'h0) begin
            rmw_d   = 1'b0;
            state_d = ST_RD0;
          end else if (mem_wstrb_i == 4'hF) begin
            rmw_d   = 1'b0;
            di_d    = mem_wdata_i;
            state_d = ST_WR;
          end else begin
            rmw_d   = 1'b1;
            state_d = ST_RD0;
          end
        end
      end
      ST_RD0: state_d = ST_RD1;
      // ram_do_i is only valid in the second rd_en cycle, so it is sampled here.
      ST_RD1: begin
        if (rmw_q) begin
          di_d    = merge_bytes(wstrb_q, wdata_q, ram_do_i);
          state_d = ST_MERGE_WR;
        end else begin
          rdata_d = ram_do_i;
          state_d = ST_RESP;
        end
      end
      ST_MERGE_WR: state_d = ST_RESP;
      ST_WR:       state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they come straight off flops.
    rd_en_d = (state_d == ST_RD0) || (state_d == ST_RD1);
    wr_en_d = (state_d == ST_MERGE_WR) || (state_d == ST_WR);
    ready_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rmw_q   <= 1'b0;
      di_q    <= '0;
      rdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rmw_q   <= rmw_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign ram_wr_en_o = wr_en_q;
  assign ram_rd_en_o = rd_en_q;
  assign ram_addr_o  = addr_q;
  assign ram_di_o    = di_q;

endmodule
`default_nettype wire
